// File: rtl/custom_types_pkg.sv
// Shared types for the memory stage: access FSM states and the MEM/WB latch layout.
package custom_types_pkg;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_REG_W  = 5;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} memstate_t;

  typedef struct packed {
    logic [MEM_REG_W-1:0]  Rw;
    logic                  RegWEN;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_DATA_W-1:0] NPC;
    logic                  halt;
  } memory_t;
endpackage

// File: rtl/mem_access_stage.sv
// MIPS memory stage: issues the dcache request, stalls upstream until dhit,
// then latches the MEM/WB register that also serves as the forwarding source.
module mem_access_stage
  import custom_types_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int REG_W  = MEM_REG_W,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              flush,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic [DATA_W-1:0] ex_port_o,
  input  logic [DATA_W-1:0] ex_port_b,
  input  logic [REG_W-1:0]  ex_Rw,
  input  logic              ex_RegWEN,
  input  logic              ex_MemtoReg,
  input  logic              ex_halt,
  input  logic [DATA_W-1:0] ex_NPC,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [DATA_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [REG_W-1:0]  mem_Rw,
  output logic              mem_RegWEN,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_NPC,
  output logic              mem_halt,
  output logic [CNT_W-1:0]  stall_cycles
);

  memstate_t         state, state_n;
  memory_t           mem_q;
  logic [DATA_W-1:0] load_q;
  logic              flush_pend;
  logic              acc, req, advance, squash;

  assign acc = (ex_dREN | ex_dWEN) & ~mem_q.halt;
  // A flush in IDLE keeps the squashed op off the bus; once in ACCESS the
  // handshake must run to dhit regardless of flush.
  assign req       = acc & ((state == ACCESS) | ((state == IDLE) & ~flush));
  assign mem_stall = req;
  assign advance   = ihit & ~mem_stall;
  assign squash    = flush | flush_pend;

  assign dmemREN   = req & ex_dREN;
  assign dmemWEN   = req & ex_dWEN & ~ex_dREN;
  assign dmemaddr  = ex_port_o;
  assign dmemstore = ex_port_b;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = dhit ? DONE : ACCESS;
      ACCESS:  if (!acc) state_n = IDLE;
               else if (dhit) state_n = DONE;
      DONE:    if (advance) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == IDLE)                flush_pend <= 1'b0;
      else if (flush && state != IDLE)    flush_pend <= 1'b1;
    end
  end

  // Stray dhits (DONE, no request) and squashed loads never touch load_q.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                         load_q <= '0;
    else if (req && dhit && ex_dREN && !squash)        load_q <= dmemload;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_q <= '0;
    end else if (!mem_stall && squash) begin
      mem_q      <= '0;
      mem_q.halt <= mem_q.halt;
    end else if (advance) begin
      mem_q.Rw     <= ex_Rw;
      mem_q.RegWEN <= ex_RegWEN;
      mem_q.wdata  <= ex_MemtoReg ? load_q : ex_port_o;
      mem_q.NPC    <= ex_NPC;
      mem_q.halt   <= mem_q.halt | ex_halt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                           stall_cycles <= '0;
    else if (mem_stall && stall_cycles != {CNT_W{1'b1}}) stall_cycles <= stall_cycles + 1'b1;
  end

  assign mem_Rw     = mem_q.Rw;
  assign mem_RegWEN = mem_q.RegWEN;
  assign mem_wdata  = mem_q.wdata;
  assign mem_NPC    = mem_q.NPC;
  assign mem_halt   = mem_q.halt;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: instruction-level reference model, directed and random ops.
module tb_mem_access_stage;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        ihit = 0, flush = 0, ex_dREN = 0, ex_dWEN = 0;
  logic [31:0] ex_port_o = 0, ex_port_b = 0, ex_NPC = 0, dmemload = 0;
  logic [4:0]  ex_Rw = 0;
  logic        ex_RegWEN = 0, ex_MemtoReg = 0, ex_halt = 0, dhit = 0;
  logic        dmemREN, dmemWEN, mem_stall, mem_RegWEN, mem_halt;
  logic [31:0] dmemaddr, dmemstore, mem_wdata, mem_NPC;
  logic [4:0]  mem_Rw;
  logic [15:0] stall_cycles;
  logic        r2, w2, st2, rwen2, h2;
  logic [31:0] a2, s2, wd2, n2;
  logic [4:0]  rw2;
  logic [1:0]  sc2;

  int n_cmp = 0, n_bad = 0;
  int exp_cnt;
  logic [31:0] last_load;
  logic exp_halt;

  always #5 CLK = ~CLK;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_port_o(ex_port_o), .ex_port_b(ex_port_b), .ex_Rw(ex_Rw), .ex_RegWEN(ex_RegWEN),
    .ex_MemtoReg(ex_MemtoReg), .ex_halt(ex_halt), .ex_NPC(ex_NPC), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .mem_Rw(mem_Rw), .mem_RegWEN(mem_RegWEN), .mem_wdata(mem_wdata),
    .mem_NPC(mem_NPC), .mem_halt(mem_halt), .stall_cycles(stall_cycles));

  mem_access_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_port_o(ex_port_o), .ex_port_b(ex_port_b), .ex_Rw(ex_Rw), .ex_RegWEN(ex_RegWEN),
    .ex_MemtoReg(ex_MemtoReg), .ex_halt(ex_halt), .ex_NPC(ex_NPC), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(r2), .dmemWEN(w2), .dmemaddr(a2), .dmemstore(s2),
    .mem_stall(st2), .mem_Rw(rw2), .mem_RegWEN(rwen2), .mem_wdata(wd2),
    .mem_NPC(n2), .mem_halt(h2), .stall_cycles(sc2));

  task automatic clear_ex();
    ex_dREN = 0; ex_dWEN = 0; ex_port_o = 0; ex_port_b = 0; ex_Rw = 0;
    ex_RegWEN = 0; ex_MemtoReg = 0; ex_halt = 0; ex_NPC = 0; flush = 0; dhit = 0; ihit = 0;
  endtask

  task automatic do_reset();
    nRST = 0; clear_ex();
    repeat (2) @(negedge CLK);
    nRST = 1;
    exp_cnt = 0; last_load = 0; exp_halt = 0;
  endtask

  // Runs one instruction through the stage: request phase of lat+1 cycles
  // (dhit on the last), then iw cycles waiting for ihit, then checks the latch.
  task automatic do_instr(input logic ld, input logic st, input logic hlt,
                          input logic [31:0] addr, input logic [31:0] sdat,
                          input logic [31:0] ldat, input logic [31:0] npc,
                          input logic [4:0] rw, input logic rwen, input logic m2r,
                          input int lat, input int iw);
    logic mem_op;
    mem_op = (ld | st) & ~exp_halt;
    ex_dREN = ld; ex_dWEN = st; ex_port_o = addr; ex_port_b = sdat; ex_NPC = npc;
    ex_Rw = rw; ex_RegWEN = rwen; ex_MemtoReg = m2r; ex_halt = hlt; flush = 0;
    if (mem_op) begin
      for (int k = 0; k <= lat; k++) begin
        dhit = (k == lat); dmemload = (k == lat) ? ldat : $urandom; ihit = 1'($urandom);
        #1;
        n_cmp++;
        if ({dmemREN, dmemWEN, mem_stall} !== {ld, st & ~ld, 1'b1} || dmemaddr !== addr || dmemstore !== sdat) begin
          n_bad++;
          $display("FAIL req_phase cyc=%0d got ren/wen/stall=%b%b%b addr=%h st=%h want %b%b1 addr=%h st=%h",
                   k, dmemREN, dmemWEN, mem_stall, dmemaddr, dmemstore, ld, st & ~ld, addr, sdat);
        end
        @(negedge CLK);
      end
    end
    for (int w = 0; w <= iw; w++) begin
      ihit = (w == iw); dhit = 1'($urandom); dmemload = $urandom;
      #1;
      n_cmp++;
      if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
        n_bad++;
        $display("FAIL idle_phase cyc=%0d got ren/wen/stall=%b%b%b want 000", w, dmemREN, dmemWEN, mem_stall);
      end
      @(negedge CLK);
    end
    ihit = 0; dhit = 0;
    if (mem_op) begin
      exp_cnt += lat + 1;
      if (ld) last_load = ldat;
    end
    exp_halt |= hlt;
    n_cmp++;
    if (mem_Rw !== rw || mem_RegWEN !== rwen || mem_wdata !== (m2r ? last_load : addr) ||
        mem_NPC !== npc || mem_halt !== exp_halt || stall_cycles !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL latch got rw=%0d we=%b wd=%h npc=%h h=%b sc=%0d want rw=%0d we=%b wd=%h npc=%h h=%b sc=%0d",
               mem_Rw, mem_RegWEN, mem_wdata, mem_NPC, mem_halt, stall_cycles,
               rw, rwen, m2r ? last_load : addr, npc, exp_halt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({dmemREN, dmemWEN, mem_stall, mem_Rw, mem_RegWEN, mem_wdata, mem_NPC, mem_halt, stall_cycles} !== '0) begin
      n_bad++;
      $display("FAIL reset got ren=%b wen=%b stall=%b wd=%h npc=%h h=%b sc=%0d want all 0",
               dmemREN, dmemWEN, mem_stall, mem_wdata, mem_NPC, mem_halt, stall_cycles);
    end
    @(negedge CLK);
  endtask

  task automatic test_lw();
    do_instr(1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h4, 5'd8, 1, 1, 2, 0);
    n_cmp++;
    if (mem_wdata !== 32'hDEADBEEF || stall_cycles !== 16'd3) begin
      n_bad++;
      $display("FAIL lw got wd=%h sc=%0d want deadbeef 3", mem_wdata, stall_cycles);
    end
  endtask

  task automatic test_sw();
    do_instr(0, 1, 0, 32'h40, 32'h1234, 32'h0, 32'h8, 5'd0, 0, 0, 0, 2);
    n_cmp++;
    if (stall_cycles !== 16'd4) begin
      n_bad++;
      $display("FAIL sw_stall got %0d want 4", stall_cycles);
    end
  endtask

  task automatic test_alu();
    do_instr(0, 0, 0, 32'hA5A5_0001, 32'h0, 32'h0, 32'hC, 5'd3, 1, 0, 0, 0);
    do_instr(0, 0, 0, 32'h0000_7777, 32'h0, 32'h0, 32'h10, 5'd4, 1, 0, 0, 3);
  endtask

  task automatic test_flush();
    // flush arriving mid-ACCESS: request runs to dhit, result dropped
    ex_dREN = 1; ex_port_o = 32'h200; ex_Rw = 5'd7; ex_RegWEN = 1; ex_MemtoReg = 1; ex_NPC = 32'h14;
    ihit = 1; dhit = 0;
    for (int k = 0; k < 4; k++) begin
      flush = (k == 1); dhit = (k == 3); dmemload = 32'hCAFE_F00D;
      #1;
      n_cmp++;
      if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
        n_bad++;
        $display("FAIL flush_hold cyc=%0d got ren=%b stall=%b want 1 1", k, dmemREN, mem_stall);
      end
      @(negedge CLK);
    end
    flush = 0; dhit = 0; ihit = 1;
    @(negedge CLK);
    exp_cnt += 4;
    n_cmp++;
    if (mem_RegWEN !== 1'b0 || mem_wdata !== 32'h0 || mem_Rw !== 5'd0 || stall_cycles !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL flush_access got we=%b wd=%h rw=%0d sc=%0d want 0 0 0 %0d",
               mem_RegWEN, mem_wdata, mem_Rw, stall_cycles, exp_cnt);
    end
    clear_ex();
    do_instr(0, 0, 0, 32'h1357, 32'h0, 32'h0, 32'h18, 5'd9, 1, 0, 0, 0);
    // flush with nothing outstanding: no request, latch cleared even without ihit
    ex_dREN = 1; ex_port_o = 32'h300; ex_Rw = 5'd5; ex_RegWEN = 1; flush = 1; ihit = 0;
    #1;
    n_cmp++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle_req got ren=%b stall=%b want 0 0", dmemREN, mem_stall);
    end
    @(negedge CLK);
    clear_ex();
    n_cmp++;
    if (mem_RegWEN !== 1'b0 || mem_wdata !== 32'h0 || mem_NPC !== 32'h0) begin
      n_bad++;
      $display("FAIL flush_idle_latch got we=%b wd=%h npc=%h want 0", mem_RegWEN, mem_wdata, mem_NPC);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [4:0] rw;
      kind = $urandom_range(0, 2);
      rw = 5'($urandom);
      do_instr(kind == 1, kind == 2, 0, $urandom, $urandom, $urandom, $urandom, rw,
               1'($urandom), kind == 1, $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    do_instr(0, 0, 0, 32'hFACE, 32'h0, 32'h0, 32'h20, 5'd2, 1, 0, 0, 0);
    ex_dREN = 1; ex_port_o = 32'h400; ex_MemtoReg = 1; dhit = 0; ihit = 1;
    repeat (2) @(negedge CLK);
    #2;
    nRST = 0; clear_ex();
    #1;
    n_cmp++;
    if ({dmemREN, mem_stall, mem_RegWEN, mem_wdata, mem_NPC, stall_cycles} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got ren=%b stall=%b we=%b wd=%h npc=%h sc=%0d want 0",
               dmemREN, mem_stall, mem_RegWEN, mem_wdata, mem_NPC, stall_cycles);
    end
    @(negedge CLK);
    nRST = 1; exp_cnt = 0; last_load = 0; exp_halt = 0;
    // fresh lw proves the FSM restarted from IDLE; 5 stall cycles saturate a 2-bit counter
    do_instr(1, 0, 0, 32'h500, 32'h0, 32'h0BAD_F00D, 32'h24, 5'd6, 1, 1, 4, 0);
    n_cmp++;
    if (sc2 !== 2'd3 || wd2 !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL cnt_sat got sc=%0d wd=%h want 3 0badf00d", sc2, wd2);
    end
  endtask

  task automatic test_halt();
    do_instr(0, 0, 1, 32'h28, 32'h0, 32'h0, 32'h28, 5'd0, 0, 0, 0, 0);
    do_instr(1, 0, 0, 32'h600, 32'h0, 32'h1111, 32'h2C, 5'd1, 1, 1, 2, 1);
    do_instr(0, 1, 0, 32'h604, 32'h99, 32'h0, 32'h30, 5'd0, 0, 0, 1, 0);
    n_cmp++;
    if (mem_halt !== 1'b1 || stall_cycles !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL halt_sticky got h=%b sc=%0d want 1 %0d", mem_halt, stall_cycles, exp_cnt);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_flush();
    test_random();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
